// File: rtl/shift_pkg.sv
// Shared types for the pipelined barrel shifter.
// Operation encoding carried alongside every word through the pipeline.
package shift_pkg;

  typedef enum logic [1:0] {
    OP_LSL = 2'd0,
    OP_LSR = 2'd1,
    OP_ASR = 2'd2,
    OP_ROL = 2'd3
  } shift_op_t;

endpackage

// File: rtl/shift_stage.sv
// One barrel stage: conditionally shifts by 2^K, then registers the word
// together with its op, amount and original sign behind a valid/ready slot.
module shift_stage
  import shift_pkg::*;
#(
  parameter int N  = 8,
  parameter int K  = 0,
  parameter int SW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  input  logic [N-1:0]  in_data,
  input  logic [SW-1:0] in_amt,
  input  logic [1:0]    in_op,
  input  logic          in_sign,
  input  logic          out_ready,
  output logic          out_valid,
  output logic [N-1:0]  out_data,
  output logic [SW-1:0] out_amt,
  output logic [1:0]    out_op,
  output logic          out_sign
);

  localparam int S = 2 ** K;
  localparam logic [N-1:0] ONES = {N{1'b1}};

  shift_op_t     op_s;
  logic [N-1:0]  shifted_s;
  logic          load_s;
  logic          valid_r;
  logic [N-1:0]  data_r;
  logic [SW-1:0] amt_r;
  logic [1:0]    op_r;
  logic          sign_r;

  assign op_s   = shift_op_t'(in_op);
  assign load_s = !valid_r || out_ready;

  // Shift by 2^K when this stage's amount bit is set; ASR fill uses the captured sign
  always_comb begin
    shifted_s = in_data;
    if (in_amt[K]) begin
      case (op_s)
        OP_LSL:  shifted_s = in_data << S;
        OP_LSR:  shifted_s = in_data >> S;
        OP_ASR:  shifted_s = (in_data >> S) | (in_sign ? ~(ONES >> S) : {N{1'b0}});
        OP_ROL:  shifted_s = (in_data << S) | (in_data >> (N - S));
        default: shifted_s = in_data;
      endcase
    end else begin
      shifted_s = in_data;
    end
  end

  // Stage slot: refills when empty or when its word moves on; payload only follows valid words
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_r <= 1'b0;
      data_r  <= {N{1'b0}};
      amt_r   <= {SW{1'b0}};
      op_r    <= 2'b00;
      sign_r  <= 1'b0;
    end else if (load_s) begin
      valid_r <= in_valid;
      if (in_valid) begin
        data_r <= shifted_s;
        amt_r  <= in_amt;
        op_r   <= in_op;
        sign_r <= in_sign;
      end
    end
  end

  assign out_valid = valid_r;
  assign out_data  = data_r;
  assign out_amt   = amt_r;
  assign out_op    = op_r;
  assign out_sign  = sign_r;

endmodule

// File: rtl/pipelined_barrel_shifter.sv
// Pipelined N-bit barrel shifter: log2(N) registered stages with an
// end-to-end valid/ready handshake and one result per cycle.
module pipelined_barrel_shifter
  import shift_pkg::*;
#(
  parameter int N = 8,
  localparam int SW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          up_valid,
  output logic          up_ready,
  input  logic [N-1:0]  up_data,
  input  logic [SW-1:0] up_amt,
  input  logic [1:0]    up_op,
  output logic          down_valid,
  input  logic          down_ready,
  output logic [N-1:0]  down_data
);

  logic [SW:0]         valid_s;
  logic [SW:0]         ready_s;
  logic [SW:0]         sign_s;
  logic [SW:0][N-1:0]  data_s;
  logic [SW:0][SW-1:0] amt_s;
  logic [SW:0][1:0]    op_s;
  logic                unused_tail_s;

  assign valid_s[0] = up_valid;
  assign data_s[0]  = up_data;
  assign amt_s[0]   = up_amt;
  assign op_s[0]    = up_op;
  assign sign_s[0]  = up_data[N-1];

  // Ready ripples back from the consumer; any empty stage downstream opens the path
  always_comb begin
    ready_s     = {(SW + 1){1'b0}};
    ready_s[SW] = down_ready;
    for (int k = SW - 1; k >= 0; k--) begin
      ready_s[k] = !valid_s[k + 1] || ready_s[k + 1];
    end
  end

  for (genvar k = 0; k < SW; k++) begin : g_stage
    shift_stage #(
      .N  (N),
      .K  (k),
      .SW (SW)
    ) u_stage (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (valid_s[k]),
      .in_data   (data_s[k]),
      .in_amt    (amt_s[k]),
      .in_op     (op_s[k]),
      .in_sign   (sign_s[k]),
      .out_ready (ready_s[k + 1]),
      .out_valid (valid_s[k + 1]),
      .out_data  (data_s[k + 1]),
      .out_amt   (amt_s[k + 1]),
      .out_op    (op_s[k + 1]),
      .out_sign  (sign_s[k + 1])
    );
  end

  assign up_ready      = ready_s[0];
  assign down_valid    = valid_s[SW];
  assign down_data     = data_s[SW];
  assign unused_tail_s = ^{amt_s[SW], op_s[SW], sign_s[SW]};

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Bench for pipelined_barrel_shifter: an N=8 and an N=16 instance checked
// against an arithmetic reference model through a scoreboard queue.
module tb_pipelined_barrel_shifter;

  logic clk, rst_n;
  logic v8, ur8, dv8, dr8;
  logic [7:0] d8, dd8;
  logic [2:0] a8;
  logic [1:0] o8;
  logic v16, ur16, dv16, dr16;
  logic [15:0] d16, dd16;
  logic [3:0] a16;
  logic [1:0] o16;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [31:0] q8[$];
  logic [31:0] q16[$];
  int c8[$];
  int occ8 = 0, occ16 = 0, acc8 = 0, acc16 = 0;
  logic took8 = 1'b0, took16 = 1'b0, stall8 = 1'b0, stall16 = 1'b0;
  logic last_ur8 = 1'b0, lat_chk = 1'b0, rnd_dr8 = 1'b0, rnd_dr16 = 1'b0;
  logic [7:0] hold8 = 8'd0;
  logic [15:0] hold16 = 16'd0;
  logic [31:0] pend8 = 32'd0, pend16 = 32'd0;

  pipelined_barrel_shifter #(.N(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .up_valid(v8), .up_ready(ur8), .up_data(d8),
    .up_amt(a8), .up_op(o8), .down_valid(dv8), .down_ready(dr8), .down_data(dd8)
  );

  pipelined_barrel_shifter #(.N(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .up_valid(v16), .up_ready(ur16), .up_data(d16),
    .up_amt(a16), .up_op(o16), .down_valid(dv16), .down_ready(dr16), .down_data(dd16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: shift of an n-bit value written as plain arithmetic on a wide word
  function automatic logic [31:0] model(input int op, input logic [31:0] din, input int amt, input int n);
    logic [31:0] m, d, r;
    m = (32'd1 << n) - 32'd1;
    d = din & m;
    case (op)
      0: r = (d << amt) & m;
      1: r = d >> amt;
      2: begin
        r = d >> amt;
        if (d[n-1]) r = r | (m & ~(m >> amt));
      end
      3: r = ((d << amt) | (d >> (n - amt))) & m;
      default: r = d;
    endcase
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h expected=%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // One clock: starts at a falling edge, samples 1 time unit before the rising edge
  task automatic tick();
    int lat;
    if (rnd_dr8) dr8 = 1'($urandom_range(0, 1));
    if (rnd_dr16) dr16 = ($urandom_range(0, 3) != 0);
    #4;
    cyc++;
    chk("up_ready8", 32'(ur8), 32'((occ8 < 3) || dr8));
    chk("up_ready16", 32'(ur16), 32'((occ16 < 4) || dr16));
    last_ur8 = ur8;
    if (stall8) begin
      chk("hold_valid8", 32'(dv8), 32'd1);
      chk("hold_data8", 32'(dd8), 32'(hold8));
    end
    if (stall16) begin
      chk("hold_valid16", 32'(dv16), 32'd1);
      chk("hold_data16", 32'(dd16), 32'(hold16));
    end
    took8 = v8 && ur8;
    if (took8) begin
      q8.push_back(pend8);
      c8.push_back(cyc);
      occ8++;
      acc8++;
    end
    took16 = v16 && ur16;
    if (took16) begin
      q16.push_back(pend16);
      occ16++;
      acc16++;
    end
    if (dv8 && dr8) begin
      if (q8.size() > 0) begin
        chk("data8", 32'(dd8), q8.pop_front());
        lat = cyc - c8.pop_front();
        if (lat_chk) chk("latency8", 32'(lat), 32'd3);
        occ8--;
      end else begin
        chk("unexpected_out8", 32'(dv8), 32'd0);
      end
    end
    if (dv16 && dr16) begin
      if (q16.size() > 0) begin
        chk("data16", 32'(dd16), q16.pop_front());
        occ16--;
      end else begin
        chk("unexpected_out16", 32'(dv16), 32'd0);
      end
    end
    stall8  = dv8 && !dr8;
    hold8   = dd8;
    stall16 = dv16 && !dr16;
    hold16  = dd16;
    @(negedge clk);
  endtask

  task automatic send8(input logic [7:0] d, input logic [2:0] a, input logic [1:0] o, input logic [31:0] e);
    v8 = 1'b1; d8 = d; a8 = a; o8 = o; pend8 = e;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (took8) break;
    end
    if (!took8) chk("accept_timeout8", 32'(took8), 32'd1);
    v8 = 1'b0;
  endtask

  task automatic send16(input logic [15:0] d, input logic [3:0] a, input logic [1:0] o, input logic [31:0] e);
    v16 = 1'b1; d16 = d; a16 = a; o16 = o; pend16 = e;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (took16) break;
    end
    if (!took16) chk("accept_timeout16", 32'(took16), 32'd1);
    v16 = 1'b0;
  endtask

  task automatic drain();
    v8 = 1'b0; v16 = 1'b0; rnd_dr8 = 1'b0; rnd_dr16 = 1'b0; dr8 = 1'b1; dr16 = 1'b1;
    for (int i = 0; i < 60; i++) begin
      if (q8.size() == 0 && q16.size() == 0) break;
      tick();
    end
    chk("drain8", 32'(q8.size()), 32'd0);
    chk("drain16", 32'(q16.size()), 32'd0);
  endtask

  initial begin
    logic [7:0] x8;
    logic [15:0] x16;
    logic [3:0] am;
    logic [1:0] op;
    int base;

    rst_n = 1'b0;
    v8 = 1'b0; d8 = 8'd0; a8 = 3'd0; o8 = 2'd0; dr8 = 1'b0;
    v16 = 1'b0; d16 = 16'd0; a16 = 4'd0; o16 = 2'd0; dr16 = 1'b0;
    #1;
    chk("rst_valid8", 32'(dv8), 32'd0);
    chk("rst_data8", 32'(dd8), 32'd0);
    chk("rst_valid16", 32'(dv16), 32'd0);
    chk("rst_data16", 32'(dd16), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk("rst_up_ready8", 32'(ur8), 32'd1);
    chk("rst_up_ready16", 32'(ur16), 32'd1);

    // Op coverage and amount boundaries, back-to-back with no backpressure
    dr8 = 1'b1; dr16 = 1'b1; lat_chk = 1'b1;
    send8(8'hB2, 3'd3, 2'd0, 32'h90);
    send8(8'hB2, 3'd3, 2'd1, 32'h16);
    send8(8'hB2, 3'd3, 2'd2, 32'hF6);
    send8(8'hB2, 3'd3, 2'd3, 32'h95);
    for (int k = 0; k < 4; k++) send8(8'hA5, 3'd0, 2'(k), 32'hA5);
    send8(8'h81, 3'd7, 2'd0, 32'h80);
    send8(8'h81, 3'd7, 2'd1, 32'h01);
    send8(8'h81, 3'd7, 2'd2, 32'hFF);
    send8(8'h81, 3'd7, 2'd3, 32'hC0);
    drain();
    lat_chk = 1'b0;

    // Backpressure: LSL by 1 with a randomly toggling consumer
    rnd_dr8 = 1'b1;
    for (int w = 0; w < 10; w++) begin
      x8 = 8'($urandom_range(0, 255));
      send8(x8, 3'd1, 2'd0, model(0, 32'(x8), 1, 8));
    end
    drain();

    // Bubble collapse: consumer stalled, offers held for five more cycles
    dr8 = 1'b0;
    base = acc8;
    x8 = 8'($urandom_range(0, 255));
    v8 = 1'b1; d8 = x8; a8 = 3'd2; o8 = 2'd3; pend8 = model(3, 32'(x8), 2, 8);
    tick();
    for (int i = 1; i <= 5; i++) begin
      if (took8) begin
        x8 = 8'($urandom_range(0, 255));
        d8 = x8; pend8 = model(3, 32'(x8), 2, 8);
      end
      tick();
      if (i == 3) chk("bubble_ready4", 32'(last_ur8), 32'd0);
    end
    chk("bubble_accepts", 32'(acc8 - base), 32'd3);
    v8 = 1'b0;

    // Reset with three words in flight
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_valid8", 32'(dv8), 32'd0);
    chk("midrst_data8", 32'(dd8), 32'd0);
    q8.delete(); c8.delete(); q16.delete();
    occ8 = 0; occ16 = 0; stall8 = 1'b0; stall16 = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    dr8 = 1'b1; dr16 = 1'b1;
    chk("midrst_up_ready8", 32'(ur8), 32'd1);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("post_rst_valid8", 32'(dv8), 32'd0);
    end

    // Randomised cross-check at N=16
    rnd_dr16 = 1'b1;
    for (int w = 0; w < 500; w++) begin
      if ($urandom_range(0, 3) == 0) tick();
      x16 = 16'($urandom_range(0, 65535));
      am = 4'($urandom_range(0, 15));
      op = 2'($urandom_range(0, 3));
      send16(x16, am, op, model(int'(op), 32'(x16), int'(am), 16));
    end
    drain();
    chk("accepted16", 32'(acc16), 32'd500);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
